rf_writeback_queue: RTL and testbench
=====================================

# rf_writeback_queue

Writeback buffer between the execution units and the register file's write port. Accepts results (destination index plus 32-bit data) over a valid/ready handshake and stores them in a small in-order FIFO. Drains at most one entry per cycle onto the register file's `rd` / `rd_data` / `write_enable` port, and offers a bypass lookup so operand reads see results that are still queued.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; must be a power of two, ≥ 2
- `XLEN`, 32: data width
- `AW`, 5: register index width (32 architectural registers)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  producer presents a result
- `in_ready`  out  1  queue can accept a result this cycle
- `in_rd`  in  AW  destination register index
- `in_data`  in  XLEN  result value
- `rf_stall`  in  1  register file write port unavailable; suppresses drain
- `rf_write_enable`  out  1  write strobe to the register file
- `rf_rd`  out  AW  destination index of the head entry
- `rf_rd_data`  out  XLEN  data of the head entry
- `rs1`, `rs2`  in  AW  operand indices to look up
- `rs1_hit`, `rs2_hit`  out  1  a queued entry targets that index
- `rs1_fwd_data`, `rs2_fwd_data`  out  XLEN  data of the youngest matching entry
- `count`  out  $clog2(DEPTH+1)  number of occupied entries
- `empty`  out  1  count == 0

## Operation
- **Storage:** circular buffer with `DEPTH` entries. Each entry holds {rd, data}. Write pointer `wp` and read pointer `rp` wrap modulo `DEPTH`. `count` is an explicit counter.
- **Accept:** a result is accepted when `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`. It depends only on registered state, never on `rf_stall` or on a same-cycle drain.
- **x0 filtering:** an accepted result with `in_rd == 0` completes its handshake but is dropped. It is not enqueued and `count` does not change.
- **Drain:**
  - `rf_write_enable = !empty && !rf_stall`.
  - `rf_rd` and `rf_rd_data` show the head entry whenever the queue is not empty, and are 0 when it is empty.
  - The head pops on the clock edge where `rf_write_enable` is 1.
- **Count update:** a simultaneous accept (non-x0) and pop leaves `count` unchanged. Accept alone adds 1, pop alone subtracts 1.
- **Order:** entries drain strictly in the order they were accepted. Multiple entries may target the same register; all of them are written, so the last write wins.
- **Bypass lookup:**
  - Combinational over the stored entries only. A result being accepted in the same cycle is not visible.
  - For each of `rs1` and `rs2`: hit = any valid entry with a matching rd. The forwarded data comes from the youngest matching entry, i.e. closest to `wp`.
  - Index 0 never hits.
  - The head entry is still visible during the cycle in which it is being written.
  - When there is no hit, the forwarded data is 0.
- **Consumer rule:** the consumer selects forwarded data over register file read data when hit = 1.

## Timing
- Reset (asynchronous): `wp = rp = count = 0`, all entries invalid. Output values during reset:
  - `in_ready = 1`, `empty = 1`
  - `rf_write_enable = 0`, `rf_rd = 0`, `rf_rd_data = 0`
  - hits 0, forwarded data 0
- Reset asserted mid-operation discards every queued entry. No register file write is issued while reset is high or in the cycle after it deasserts.
- Latency: a result accepted at edge N appears on the rf port and in bypass lookup in cycle N+1. The earliest register file write is at edge N+1.
- Throughput: one accept and one drain per cycle, sustained.
- Full: with `count == DEPTH`, `in_ready = 0` even if a pop occurs in the same cycle. `in_ready` returns to 1 the cycle after the pop.
- Stall: while `rf_stall = 1`, the head is held and `rp` and the rf outputs are stable. Accepts continue until the queue is full.
- Pointer wrap: `wp` and `rp` go from `DEPTH-1` back to 0 with no bubble.

## Test plan
- **Basic drain:** after reset, accept (x1, 0x12345678) then (x2, 0x87654321) on consecutive cycles with `rf_stall = 0`.
  - `rf_write_enable` is high for exactly two cycles, showing x1/0x12345678 then x2/0x87654321.
  - `empty` returns to 1.
- **x0 drop:** accept (x0, 0xDEADBEEF). Response: `in_ready` stays 1, `count` stays 0, and no write is issued. Lookup with `rs1 = 0` gives `rs1_hit = 0` and data 0.
- **Full/stall:**
  - Hold `rf_stall = 1` and offer 5 results to x3..x7. The first 4 are accepted, then `count = 4` and `in_ready = 0`, and the 5th waits.
  - Release the stall. Writes go out in order x3..x6, then x7 is accepted and written.
- **Youngest-wins bypass:**
  - Under stall, enqueue (x5, 0xAAAA0001) then (x5, 0xBBBB0002), and set `rs2 = 5`. Response: `rs2_hit = 1` and `rs2_fwd_data = 0xBBBB0002`.
  - Unstall for one cycle. Data stays 0xBBBB0002.
  - After both entries pop, `rs2_hit = 0`.
- **Wrap and concurrency:** stream 10 back-to-back results to x1..x10 with no stall. Response:
  - `count` stays at 1 after the first cycle.
  - Writes occur in order, each one cycle after its acceptance.
  - The pointers wrap twice with no bubble.
- **Mid-operation reset:** with 3 entries queued and the stall active, pulse `reset` asynchronously between edges. Response: `count = 0`, `empty = 1`, `rf_write_enable = 0` immediately, and no stale write after release.

Source files
------------

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO between execution units and the register file write port,
// with a youngest-match bypass lookup over the queued results.
module rf_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic            rf_stall,
    output logic            rf_write_enable,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_rd_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_hit,
    output logic            rs2_hit,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic [XLEN-1:0] rs2_fwd_data,
    output logic [CW-1:0]   count,
    output logic            empty
);

    logic [AW-1:0]   r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic [PW-1:0]   w_idx;

    assign empty           = (r_count == '0);
    assign count           = r_count;
    assign in_ready        = (r_count != CW'(DEPTH));
    assign rf_write_enable = !empty && !rf_stall;
    assign rf_rd           = empty ? '0 : r_rd[r_rp];
    assign rf_rd_data      = empty ? '0 : r_data[r_rp];

    // x0 results complete the handshake but never occupy a slot
    assign w_push = in_valid && in_ready && (in_rd != '0);
    assign w_pop  = rf_write_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_rd[r_wp]   <= in_rd;
                r_data[r_wp] <= in_data;
                r_wp         <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one
    always_comb begin
        rs1_hit      = 1'b0;
        rs2_hit      = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        w_idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rp + PW'(k);
            if (CW'(k) < r_count) begin
                if ((rs1 != '0) && (r_rd[w_idx] == rs1)) begin
                    rs1_hit      = 1'b1;
                    rs1_fwd_data = r_data[w_idx];
                end
                if ((rs2 != '0) && (r_rd[w_idx] == rs2)) begin
                    rs2_hit      = 1'b1;
                    rs2_fwd_data = r_data[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_writeback_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rd;
    logic [XLEN-1:0] in_data;
    logic            rf_stall;
    logic            rf_write_enable;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_rd_data;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [XLEN-1:0] rs1_fwd_data;
    logic [XLEN-1:0] rs2_fwd_data;
    logic [CW-1:0]   count;
    logic            empty;

    rf_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rd           (in_rd),
        .in_data         (in_data),
        .rf_stall        (rf_stall),
        .rf_write_enable (rf_write_enable),
        .rf_rd           (rf_rd),
        .rf_rd_data      (rf_rd_data),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_hit         (rs1_hit),
        .rs2_hit         (rs2_hit),
        .rs1_fwd_data    (rs1_fwd_data),
        .rs2_fwd_data    (rs2_fwd_data),
        .count           (count),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {rd, data}, oldest at index 0
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;
    entry_t mq[$];
    int     wr_log[$];
    bit     cmp_en = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            automatic bit do_pop  = (mq.size() != 0) && !rf_stall;
            automatic bit do_push = in_valid && (mq.size() < DEPTH) && (in_rd != 0);
            entry_t e;
            e.rd   = in_rd;
            e.data = in_data;
            if (do_pop) begin
                wr_log.push_back(int'(mq[0].rd));
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back(e);
        end
    end

    task automatic model_lookup(input logic [AW-1:0] rs, output logic hit,
                                output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (rs != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == rs) begin
                    hit  = 1'b1;
                    data = mq[i].data;
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            logic            h1, h2;
            logic [XLEN-1:0] d1, d2;
            automatic int    n = mq.size();
            model_lookup(rs1, h1, d1);
            model_lookup(rs2, h2, d2);
            chk("m_in_ready", in_ready, n < DEPTH);
            chk("m_count", count, n);
            chk("m_empty", empty, n == 0);
            chk("m_we", rf_write_enable, (n != 0) && !rf_stall);
            chk("m_rf_rd", rf_rd, (n != 0) ? mq[0].rd : '0);
            chk("m_rf_data", rf_rd_data, (n != 0) ? mq[0].data : '0);
            chk("m_rs1_hit", rs1_hit, h1);
            chk("m_rs1_data", rs1_fwd_data, d1);
            chk("m_rs2_hit", rs2_hit, h2);
            chk("m_rs2_data", rs2_fwd_data, d2);
        end
    end

    int wr_cnt = 0;
    always @(posedge clk) if (rf_write_enable) wr_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit done;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        rf_stall = 1'b0;
        rs1      = '0;
        rs2      = '0;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_we", rf_write_enable, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_data", rf_rd_data, 0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        step();

        // Basic drain
        base = wr_cnt;
        in_valid = 1'b1; in_rd = 5'd1; in_data = 32'h12345678;
        step();
        in_rd = 5'd2; in_data = 32'h87654321;
        chk("bd_rd1", rf_rd, 1);
        chk("bd_data1", rf_rd_data, 32'h12345678);
        chk("bd_we1", rf_write_enable, 1);
        step();
        in_valid = 1'b0;
        chk("bd_rd2", rf_rd, 2);
        chk("bd_data2", rf_rd_data, 32'h87654321);
        step();
        step();
        chk("bd_empty", empty, 1);
        chk("bd_writes", wr_cnt - base, 2);

        // x0 drop
        base = wr_cnt;
        in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hDEADBEEF; rs1 = 5'd0;
        chk("x0_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("x0_ready_after", in_ready, 1);
        chk("x0_count", count, 0);
        chk("x0_rs1_hit", rs1_hit, 0);
        chk("x0_rs1_data", rs1_fwd_data, 0);
        step();
        chk("x0_writes", wr_cnt - base, 0);

        // Full / stall
        wr_log.delete();
        rf_stall = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h1100 + i;
            step();
        end
        in_rd = 5'd7; in_data = 32'h1107;
        chk("fs_count", count, 4);
        chk("fs_ready", in_ready, 0);
        step();
        chk("fs_count_hold", count, 4);
        chk("fs_head_hold", rf_rd, 3);
        rf_stall = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            done = in_ready;
            step();
        end
        chk("fs_x7_accepted", done, 1);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && !empty; k++) step();
        chk("fs_drained", empty, 1);
        chk("fs_nwr", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("fs_order", wr_log[i], i + 3);

        // Youngest-wins bypass
        rf_stall = 1'b1;
        rs2 = 5'd5;
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hAAAA0001;
        step();
        in_data = 32'hBBBB0002;
        chk("yw_first", rs2_fwd_data, 32'hAAAA0001);
        step();
        in_valid = 1'b0;
        chk("yw_hit", rs2_hit, 1);
        chk("yw_data", rs2_fwd_data, 32'hBBBB0002);
        rf_stall = 1'b0;
        step();
        rf_stall = 1'b1;
        chk("yw_data_after1", rs2_fwd_data, 32'hBBBB0002);
        chk("yw_count1", count, 1);
        rf_stall = 1'b0;
        step();
        chk("yw_nohit", rs2_hit, 0);
        chk("yw_empty", empty, 1);
        rs2 = 5'd0;

        // Wrap and concurrency
        wr_log.delete();
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + i;
            step();
            chk("wr_count", count, 1);
            chk("wr_head", rf_rd, i);
            chk("wr_we", rf_write_enable, 1);
        end
        in_valid = 1'b0;
        step();
        chk("wr_empty", empty, 1);
        chk("wr_nwr", wr_log.size(), 10);
        for (int i = 0; i < 10 && i < wr_log.size(); i++) chk("wr_order", wr_log[i], i + 1);

        // Mid-operation reset
        rf_stall = 1'b1;
        for (int i = 8; i <= 10; i++) begin
            in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h200 + i;
            step();
        end
        in_valid = 1'b0;
        chk("mr_count3", count, 3);
        #1 reset = 1'b1;
        #1;
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_we", rf_write_enable, 0);
        #1 reset = 1'b0;
        rf_stall = 1'b0;
        base = wr_cnt;
        step();
        step();
        step();
        chk("mr_nostale", wr_cnt - base, 0);
        chk("mr_empty_after", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
